// File: rtl/sipo_pkg.sv
// Shared state encoding for the serial link control (PISO and SIPO sides).
package sipo_pkg;
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;
endpackage

// File: rtl/dffr_n.sv
// 1-bit D flip-flop, asynchronous active-low reset to 0.
module dffr_n (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  always_ff @(posedge clk or negedge rst)
    if (!rst) q <= 1'b0;
    else      q <= d;
endmodule

// File: rtl/sipo_deser.sv
// Serial-in parallel-out deserializer: MSB-first bits, one-word valid/ready output
// register, sticky overrun flag for words dropped under backpressure.
module sipo_deser
  import sipo_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ser_in,
  input  logic             ser_en,
  input  logic             sof,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy,
  output logic             overrun,
  input  logic             clr_ovr
);
  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] word;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             state, state_nxt;
  logic             complete, out_free, load;
  logic             out_valid_nxt, overrun_nxt;

  assign word     = {sr[WIDTH-2:0], ser_in};
  // sof with ser_en starts a new word, so it can never complete one
  assign complete = ser_en & ~sof & (cnt == CNT_LAST);
  assign out_free = ~out_valid | out_ready;
  assign load     = complete & out_free;
  assign busy     = (state == ST_SHIFT);

  always_comb begin
    cnt_nxt   = cnt;
    state_nxt = state;
    if (sof) begin
      cnt_nxt   = ser_en ? CNT_ONE : '0;
      state_nxt = ser_en ? ST_SHIFT : ST_IDLE;
    end else if (ser_en) begin
      if (complete) begin
        cnt_nxt   = '0;
        state_nxt = ST_IDLE;
      end else begin
        cnt_nxt   = cnt + CNT_ONE;
        state_nxt = ST_SHIFT;
      end
    end
  end

  always_comb begin
    out_valid_nxt = out_valid;
    if (load)                        out_valid_nxt = 1'b1;
    else if (out_valid && out_ready) out_valid_nxt = 1'b0;
    overrun_nxt = overrun;
    if (complete && !out_free)       overrun_nxt = 1'b1;
    else if (clr_ovr)                overrun_nxt = 1'b0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sr       <= '0;
      cnt      <= '0;
      out_data <= '0;
    end else begin
      if (ser_en) sr <= word;
      cnt <= cnt_nxt;
      if (load) out_data <= word;
    end
  end

  dffr_n u_state   (.clk(clk), .rst(rst), .d(state_nxt),     .q(state));
  dffr_n u_valid   (.clk(clk), .rst(rst), .d(out_valid_nxt), .q(out_valid));
  dffr_n u_overrun (.clk(clk), .rst(rst), .d(overrun_nxt),   .q(overrun));
endmodule

// File: tb/tb_sipo_deser.sv
// Directed bench for sipo_deser (WIDTH=4) with hand-computed expectations.
module tb_sipo_deser;
  logic       clk = 1'b0;
  logic       rst;
  logic       ser_in, ser_en, sof, out_ready, clr_ovr;
  logic [3:0] out_data;
  logic       out_valid, busy, overrun;

  int vectors = 0;
  int miscompares = 0;

  sipo_deser #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .ser_in(ser_in), .ser_en(ser_en), .sof(sof),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy), .overrun(overrun), .clr_ovr(clr_ovr)
  );

  always #5 clk = ~clk;

  // advance one edge; inputs change and outputs are sampled 1ns after it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ser_en = 1'b1;
    ser_in = b;
    tick();
    ser_en = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; ser_in = 0; ser_en = 0; sof = 0; out_ready = 1; clr_ovr = 0;
    tick(); tick();
    vectors++; if (out_data !== 4'h0) begin $display("FAIL reset_data got %h want %h", out_data, 4'h0); miscompares++; end
    vectors++; if (out_valid !== 1'b0) begin $display("FAIL reset_valid got %b want 0", out_valid); miscompares++; end
    vectors++; if (busy !== 1'b0) begin $display("FAIL reset_busy got %b want 0", busy); miscompares++; end
    vectors++; if (overrun !== 1'b0) begin $display("FAIL reset_overrun got %b want 0", overrun); miscompares++; end
    rst = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [3:0] bits = 4'b1011;
    out_ready = 1'b1;
    ser_en = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      ser_in = bits[i];
      tick();
      vectors++; if (busy !== 1'b1) begin $display("FAIL basic_busy bit %0d got %b want 1", 3-i, busy); miscompares++; end
      vectors++; if (out_valid !== 1'b0) begin $display("FAIL basic_early_valid bit %0d got %b want 0", 3-i, out_valid); miscompares++; end
    end
    ser_in = bits[0];
    tick();
    ser_en = 1'b0;
    vectors++; if (out_valid !== 1'b1) begin $display("FAIL basic_valid got %b want 1", out_valid); miscompares++; end
    vectors++; if (out_data !== 4'hB) begin $display("FAIL basic_data got %h want %h", out_data, 4'hB); miscompares++; end
    vectors++; if (busy !== 1'b0) begin $display("FAIL basic_busy_done got %b want 0", busy); miscompares++; end
    tick();
    vectors++; if (out_valid !== 1'b0) begin $display("FAIL basic_valid_pulse got %b want 0", out_valid); miscompares++; end
    vectors++; if (out_data !== 4'hB) begin $display("FAIL basic_data_hold got %h want %h", out_data, 4'hB); miscompares++; end
  endtask

  task automatic test_gap();
    send_bit(1'b1);
    send_bit(1'b0);
    for (int g = 0; g < 3; g++) begin
      tick();
      vectors++; if (busy !== 1'b1) begin $display("FAIL gap_busy cycle %0d got %b want 1", g, busy); miscompares++; end
      vectors++; if (out_valid !== 1'b0) begin $display("FAIL gap_valid cycle %0d got %b want 0", g, out_valid); miscompares++; end
    end
    send_bit(1'b1);
    send_bit(1'b1);
    vectors++; if (out_valid !== 1'b1) begin $display("FAIL gap_valid_done got %b want 1", out_valid); miscompares++; end
    vectors++; if (out_data !== 4'hB) begin $display("FAIL gap_data got %h want %h", out_data, 4'hB); miscompares++; end
    tick();
  endtask

  task automatic test_overrun();
    logic [7:0] bits = 8'hA5;
    out_ready = 1'b0;
    for (int i = 7; i >= 4; i--) send_bit(bits[i]);
    vectors++; if (out_data !== 4'hA) begin $display("FAIL ovr_first got %h want %h", out_data, 4'hA); miscompares++; end
    for (int i = 3; i >= 0; i--) send_bit(bits[i]);
    vectors++; if (out_data !== 4'hA) begin $display("FAIL ovr_hold_data got %h want %h", out_data, 4'hA); miscompares++; end
    vectors++; if (out_valid !== 1'b1) begin $display("FAIL ovr_valid got %b want 1", out_valid); miscompares++; end
    vectors++; if (overrun !== 1'b1) begin $display("FAIL ovr_set got %b want 1", overrun); miscompares++; end
    clr_ovr = 1'b1;
    tick();
    clr_ovr = 1'b0;
    vectors++; if (overrun !== 1'b0) begin $display("FAIL ovr_clear got %b want 0", overrun); miscompares++; end
    vectors++; if (out_valid !== 1'b1) begin $display("FAIL ovr_valid_after_clr got %b want 1", out_valid); miscompares++; end
    // a drop and a clear on the same edge: the drop wins
    for (int i = 3; i >= 1; i--) send_bit(bits[i]);
    clr_ovr = 1'b1;
    send_bit(bits[0]);
    clr_ovr = 1'b0;
    vectors++; if (overrun !== 1'b1) begin $display("FAIL ovr_set_wins got %b want 1", overrun); miscompares++; end
    clr_ovr = 1'b1;
    out_ready = 1'b1;
    tick();
    clr_ovr = 1'b0;
    vectors++; if (out_valid !== 1'b0) begin $display("FAIL ovr_drain got %b want 0", out_valid); miscompares++; end
    vectors++; if (out_data !== 4'hA) begin $display("FAIL ovr_drain_data got %h want %h", out_data, 4'hA); miscompares++; end
    vectors++; if (overrun !== 1'b0) begin $display("FAIL ovr_clear2 got %b want 0", overrun); miscompares++; end
  endtask

  task automatic test_handshake();
    // transfer and a new completion on the same edge keep out_valid high
    out_ready = 1'b0;
    send_bit(1); send_bit(0); send_bit(1); send_bit(0);
    send_bit(0); send_bit(1); send_bit(0);
    vectors++; if (out_data !== 4'hA) begin $display("FAIL hs_stable got %h want %h", out_data, 4'hA); miscompares++; end
    out_ready = 1'b1;
    send_bit(1);
    vectors++; if (out_data !== 4'h5) begin $display("FAIL hs_reload got %h want %h", out_data, 4'h5); miscompares++; end
    vectors++; if (out_valid !== 1'b1) begin $display("FAIL hs_valid_stays got %b want 1", out_valid); miscompares++; end
    vectors++; if (overrun !== 1'b0) begin $display("FAIL hs_no_ovr got %b want 0", overrun); miscompares++; end
    tick();
    vectors++; if (out_valid !== 1'b0) begin $display("FAIL hs_drain got %b want 0", out_valid); miscompares++; end
  endtask

  task automatic test_sof();
    out_ready = 1'b1;
    send_bit(1); send_bit(1);
    sof = 1'b1;
    send_bit(0);
    sof = 1'b0;
    vectors++; if (busy !== 1'b1) begin $display("FAIL sof_busy got %b want 1", busy); miscompares++; end
    vectors++; if (out_valid !== 1'b0) begin $display("FAIL sof_no_word got %b want 0", out_valid); miscompares++; end
    send_bit(0); send_bit(1); send_bit(1);
    vectors++; if (out_valid !== 1'b1) begin $display("FAIL sof_valid got %b want 1", out_valid); miscompares++; end
    vectors++; if (out_data !== 4'h3) begin $display("FAIL sof_data got %h want %h", out_data, 4'h3); miscompares++; end
    tick();
    // sof without ser_en discards the partial word
    send_bit(1); send_bit(0);
    sof = 1'b1;
    tick();
    sof = 1'b0;
    vectors++; if (busy !== 1'b0) begin $display("FAIL sof_abort_busy got %b want 0", busy); miscompares++; end
    send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    vectors++; if (out_data !== 4'h6) begin $display("FAIL sof_abort_data got %h want %h", out_data, 4'h6); miscompares++; end
    vectors++; if (out_valid !== 1'b1) begin $display("FAIL sof_abort_valid got %b want 1", out_valid); miscompares++; end
    tick();
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    send_bit(1); send_bit(0); send_bit(1); send_bit(0);
    send_bit(0); send_bit(1); send_bit(0); send_bit(1);
    send_bit(1); send_bit(1); send_bit(1);
    vectors++; if ({busy, out_valid, overrun} !== 3'b111) begin $display("FAIL ar_setup got %b want 111", {busy, out_valid, overrun}); miscompares++; end
    rst = 1'b0;
    #2;
    vectors++; if (busy !== 1'b0) begin $display("FAIL ar_busy got %b want 0", busy); miscompares++; end
    vectors++; if (out_valid !== 1'b0) begin $display("FAIL ar_valid got %b want 0", out_valid); miscompares++; end
    vectors++; if (overrun !== 1'b0) begin $display("FAIL ar_overrun got %b want 0", overrun); miscompares++; end
    vectors++; if (out_data !== 4'h0) begin $display("FAIL ar_data got %h want %h", out_data, 4'h0); miscompares++; end
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    send_bit(0); send_bit(1); send_bit(1); send_bit(0);
    vectors++; if (out_data !== 4'h6) begin $display("FAIL ar_next_word got %h want %h", out_data, 4'h6); miscompares++; end
    vectors++; if (out_valid !== 1'b1) begin $display("FAIL ar_next_valid got %b want 1", out_valid); miscompares++; end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits = 8'hC3;
    logic [7:0] exp_v = 8'b1000_1000;  // valid after edges 4 and 8 (index = edge-1)
    out_ready = 1'b1;
    ser_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ser_in = bits[7-i];
      tick();
      vectors++; if (out_valid !== exp_v[i]) begin $display("FAIL b2b_valid_map edge %0d got %b want %b", i+1, out_valid, exp_v[i]); miscompares++; end
      vectors++; if (out_valid !== ((i % 4) == 3)) begin $display("FAIL b2b_valid edge %0d got %b want %b", i+1, out_valid, ((i % 4) == 3)); miscompares++; end
      if (i == 3) begin
        vectors++; if (out_data !== 4'hC) begin $display("FAIL b2b_first got %h want %h", out_data, 4'hC); miscompares++; end
      end
      if (i == 7) begin
        vectors++; if (out_data !== 4'h3) begin $display("FAIL b2b_second got %h want %h", out_data, 4'h3); miscompares++; end
      end
    end
    ser_en = 1'b0;
    tick();
    vectors++; if (out_valid !== 1'b0) begin $display("FAIL b2b_drain got %b want 0", out_valid); miscompares++; end
    vectors++; if (overrun !== 1'b0) begin $display("FAIL b2b_overrun got %b want 0", overrun); miscompares++; end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_gap();
    test_overrun();
    test_handshake();
    test_sof();
    test_async_reset();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
